// File: rtl/regfile_param.sv
// regfile_param: parameterised register file, two combinational read ports,
// one write port, and a hardware zero sweep.
//
// A sweep runs after every reset and on each clear_req seen in IDLE. It writes
// zero to one register per cycle, starting at register 0. The sweep lasts
// exactly NREGS cycles. While it runs, busy is high, both read ports return 0,
// and any write is discarded; wr_drop pulses in the following cycle.
//
// Parameters:
//   DATA_W   register width
//   ADDR_W   address width, NREGS = 2**ADDR_W
//   ZERO_REG 1 -> register 0 always reads 0 and ignores writes (no wr_drop)
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   clear_req / busy                 sweep request / sweep in progress
//   reg_write_enable/_addr/_data     write port
//   wr_drop                          registered pulse: previous-cycle write discarded
//   reg_read_addr1/2, reg_data1/2    combinational read ports
//
// Optional build macro REGFILE_BYPASS_EN: an accepted write is forwarded
// to a read port with the same address in the same cycle.
module regfile_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    input  logic              reg_write_enable,
    input  logic [ADDR_W-1:0] reg_write_addr,
    input  logic [DATA_W-1:0] reg_write_data,
    output logic              wr_drop,
    input  logic [ADDR_W-1:0] reg_read_addr1,
    input  logic [ADDR_W-1:0] reg_read_addr2,
    output logic [DATA_W-1:0] reg_data1,
    output logic [DATA_W-1:0] reg_data2
);
    localparam int NREGS = 2**ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [NREGS];

    logic wr_hard0;   // write aimed at the hardwired-zero register
    logic wr_accept;  // write that will land at the next edge

    assign busy      = (state == S_CLEAR);
    assign wr_hard0  = (ZERO_REG != 0) && (reg_write_addr == '0);
    assign wr_accept = reg_write_enable && !busy && !wr_hard0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            wr_drop <= 1'b0;
        end else begin
            // Writes to the hardwired-zero register are silently ignored,
            // never reported as dropped.
            wr_drop <= reg_write_enable && busy && !wr_hard0;
            case (state)
                S_CLEAR: begin
                    // clr_cnt wraps back to 0 as the last register is cleared.
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(NREGS-1))
                        state <= S_IDLE;
                end
                default: begin
                    if (clear_req) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Storage has no reset. rst only blocks updates, which keeps the
    // FSM holding with no sweep progress and no writes during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy)
                mem[clr_cnt] <= '0;
            else if (wr_accept)
                mem[reg_write_addr] <= reg_write_data;
        end
    end

    always_comb begin
        reg_data1 = mem[reg_read_addr1];
        if (busy || ((ZERO_REG != 0) && reg_read_addr1 == '0))
            reg_data1 = '0;
        else if (BYPASS && wr_accept && reg_write_addr == reg_read_addr1)
            reg_data1 = reg_write_data;
    end

    always_comb begin
        reg_data2 = mem[reg_read_addr2];
        if (busy || ((ZERO_REG != 0) && reg_read_addr2 == '0))
            reg_data2 = '0;
        else if (BYPASS && wr_accept && reg_write_addr == reg_read_addr2)
            reg_data2 = reg_write_data;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width; NREGS = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 0, meaning that when 1, register 0 is hardwired to zero.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, an asynchronous active-high reset.
REQ-006 The block SHALL have port clear_req, input, 1 bit, which requests a zero sweep of all registers.
REQ-007 The block SHALL have port busy, output, 1 bit, high while the sweep runs.
REQ-008 The block SHALL have port reg_write_enable, input, 1 bit, the write strobe.
REQ-009 The block SHALL have port reg_write_addr, input, ADDR_W bits, the write address.
REQ-010 The block SHALL have port reg_write_data, input, DATA_W bits, the write data.
REQ-011 The block SHALL have port wr_drop, output, 1 bit, a registered one-cycle pulse indicating a write was discarded.
REQ-012 The block SHALL have ports reg_read_addr1 and reg_read_addr2, input, ADDR_W bits each, the read addresses.
REQ-013 The block SHALL have ports reg_data1 and reg_data2, output, DATA_W bits each, combinational read data.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and CLEAR, plus a sweep counter clr_cnt of ADDR_W bits.
REQ-015 In CLEAR, each cycle SHALL write 0 to register clr_cnt and increment clr_cnt.
REQ-016 CLEAR SHALL exit to IDLE on the edge that writes register NREGS-1, so the sweep lasts exactly NREGS cycles.
REQ-017 busy SHALL equal (state == CLEAR).
REQ-018 In IDLE, clear_req=1 at an edge SHALL enter CLEAR with clr_cnt=0 on that edge.
REQ-019 clear_req asserted during CLEAR SHALL be ignored: no restart and no extension of the sweep.
REQ-020 In IDLE, reg_write_enable=1 SHALL write reg_write_data to reg_write_addr at the edge.
REQ-021 A write presented while busy=1 SHALL be discarded, and wr_drop SHALL be 1 for the following cycle.
REQ-022 wr_drop SHALL be 0 in every other cycle.
REQ-023 A write that coincides with clear_req in IDLE SHALL take effect, and the sweep SHALL then overwrite that register with zero.
REQ-024 While busy=1, reg_data1 and reg_data2 SHALL read 0 regardless of address.
REQ-025 When ZERO_REG=1, reads of address 0 SHALL return 0, and writes to address 0 SHALL be ignored without asserting wr_drop.
REQ-026 The two read ports SHALL be independent; identical addresses SHALL return identical data.

Reset
REQ-027 Assertion of rst SHALL immediately force state=CLEAR, clr_cnt=0, busy=1 and wr_drop=0.
REQ-028 While rst=1, the FSM SHALL hold, with no sweep progress and no writes.
REQ-029 The sweep SHALL begin on the first rising edge after rst deasserts.
REQ-030 busy SHALL fall NREGS cycles after rst deasserts.
REQ-031 Register contents SHALL be don't-care until the sweep completes; reads return 0 per REQ-024.
REQ-032 rst asserted mid-sweep or mid-write SHALL restart the sweep from clr_cnt=0.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-034 With REGFILE_BYPASS_EN defined, in IDLE with reg_write_enable=1 and read address == write address (and not hardwired zero), the read port SHALL return reg_write_data in the same cycle.
REQ-035 Without REGFILE_BYPASS_EN, the read port SHALL return the old contents until after the edge.
REQ-036 REGFILE_BYPASS_EN SHALL never forward a write that is being dropped.

Verification
REQ-037 Bench SHALL cover: rst pulse, then release -> busy=1 for exactly 16 cycles (defaults); all reads 0 during the sweep; busy=0 on cycle 17.
REQ-038 Bench SHALL cover: IDLE, write 0xBEEF to r5, next cycle read addr1=5 and addr2=5 -> both 0xBEEF.
REQ-039 Bench SHALL cover: write 0x1234 to r3 while busy=1 -> wr_drop=1 for one cycle; after the sweep, r3 reads 0x0000.
REQ-040 Bench SHALL cover: ZERO_REG=1, write 0xFFFF to r0 -> r0 reads 0x0000 and wr_drop stays 0.
REQ-041 Bench SHALL cover: with REGFILE_BYPASS_EN, write 0xA5A5 to r7 with addr1=7 in the same cycle -> reg_data1=0xA5A5 before the edge; without the macro -> the old value.
REQ-042 Bench SHALL cover: clear_req at sweep cycle 8 -> sweep still ends at 16 cycles; rst at sweep cycle 8 -> busy lasts 16 cycles after release.
